// File: rtl/x_uart_tx_fifo.sv
// x_uart_tx_fifo: UART transmitter with a small transmit FIFO.
// Configurable character width, optional even/odd parity, and 1 or 2 stop bits.
// Upstream queues characters with i_valid/o_accept. The shifter pops the FIFO
// head whenever it is idle.
// Optional line-break generation: define X_UART_TX_FIFO_BREAK_EN to add i_break.
module x_uart_tx_fifo #(
   parameter int p_clk_hz     = 12000000,
   parameter int p_baud       = 115200,
   parameter int p_data_bits  = 8,
   parameter int p_fifo_depth = 4
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic [p_data_bits-1:0]          i_data,
   input  logic                            i_valid,
   output logic                            o_accept,
   input  logic [1:0]                      i_parity,
   input  logic                            i_stop2,
`ifdef X_UART_TX_FIFO_BREAK_EN
   input  logic                            i_break,
`endif
   output logic                            o_tx,
   output logic                            o_busy,
   output logic [$clog2(p_fifo_depth):0]   o_level
);

   localparam int unsigned c_div  = p_clk_hz / p_baud;
   localparam int          c_tw   = (c_div > 1) ? $clog2(c_div) : 1;
   localparam int          c_bw   = $clog2(p_data_bits + 1);
   localparam int          c_aw   = $clog2(p_fifo_depth);
   localparam logic [c_tw-1:0] c_tmax = c_tw'(c_div - 1);
   localparam logic [c_bw-1:0] c_bmax = c_bw'(p_data_bits - 1);

   // S_BRK and S_MAB are only reachable when break generation is built in.
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP1,
      S_STOP2,
      S_BRK,
      S_MAB
   } state_t;

   state_t                  state_q, state_d;
   logic [c_tw-1:0]         timer_q, timer_d;
   logic [c_bw-1:0]         bitcnt_q, bitcnt_d;
   logic [p_data_bits-1:0]  shifter_q, shifter_d;
   logic                    par_en_q, par_en_d;
   logic                    par_bit_q, par_bit_d;
   logic                    stop2_q, stop2_d;
   logic                    tx_q, tx_d;
   logic [c_aw:0]           wr_ptr_q, wr_ptr_d;
   logic [c_aw:0]           rd_ptr_q, rd_ptr_d;
   logic [p_data_bits-1:0]  mem_q [p_fifo_depth];

   logic                    full;
   logic                    empty;
   logic                    push;
   logic                    pop;
   logic                    timer_end;
   logic                    brk_req;
   logic [p_data_bits-1:0]  head;

`ifdef X_UART_TX_FIFO_BREAK_EN
   assign brk_req = i_break;
`else
   assign brk_req = 1'b0;
`endif

   // FIFO status: the extra pointer MSB separates full from empty
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                     (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);
   assign push     = i_valid & ~full;
   assign head     = mem_q[rd_ptr_q[c_aw-1:0]];
   assign o_accept = push;
   assign o_level  = wr_ptr_q - rd_ptr_q;
   assign o_tx     = tx_q;
   assign o_busy   = (state_q != S_IDLE) | brk_req;

   // Pointer advance; wrap is implicit in the modulo-2*depth pointer width
   always_comb begin
      wr_ptr_d = wr_ptr_q + (c_aw + 1)'(push);
      rd_ptr_d = rd_ptr_q + (c_aw + 1)'(pop);
   end

   // Character sequencing, pop decision and next line level
   always_comb begin
      state_d   = state_q;
      bitcnt_d  = bitcnt_q;
      shifter_d = shifter_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      stop2_d   = stop2_q;
      pop       = 1'b0;
      tx_d      = 1'b1;
      timer_end = (timer_q == c_tmax);

      if ((state_q == S_IDLE) || (state_q == S_BRK)) begin
         timer_d = '0;
      end else if (timer_end) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (brk_req) begin
               state_d = S_BRK;
            end else if (!empty) begin
               pop = 1'b1;
            end
         end
         S_START: begin
            if (timer_end) begin
               state_d  = S_DATA;
               bitcnt_d = '0;
            end
         end
         S_DATA: begin
            if (timer_end) begin
               shifter_d = shifter_q >> 1;
               if (bitcnt_q == c_bmax) begin
                  state_d = par_en_q ? S_PARITY : S_STOP1;
               end else begin
                  bitcnt_d = bitcnt_q + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (timer_end) state_d = S_STOP1;
         end
         S_STOP1: begin
            if (timer_end) state_d = stop2_q ? S_STOP2 : S_IDLE;
         end
         S_STOP2: begin
            if (timer_end) state_d = S_IDLE;
         end
         S_BRK: begin
            if (!brk_req) state_d = S_MAB;
         end
         S_MAB: begin
            // The mark-after-break period runs straight into the next start bit
            if (timer_end) begin
               if (!empty && !brk_req) begin
                  pop = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Load the head character and freeze the frame format for its duration
      if (pop) begin
         shifter_d = head;
         par_en_d  = (i_parity == 2'b01) || (i_parity == 2'b10);
         par_bit_d = (^head) ^ (i_parity == 2'b10);
         stop2_d   = i_stop2;
         state_d   = S_START;
         timer_d   = '0;
      end

      case (state_d)
         S_START, S_BRK: tx_d = 1'b0;
         S_DATA:         tx_d = shifter_d[0];
         S_PARITY:       tx_d = par_bit_d;
         default:        tx_d = 1'b1;
      endcase
   end

   // Control state; reset aborts any character and returns the line to mark
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         bitcnt_q  <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         stop2_q   <= 1'b0;
         tx_q      <= 1'b1;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bitcnt_q  <= bitcnt_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         stop2_q   <= stop2_d;
         tx_q      <= tx_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   // Data storage needs no reset: FIFO slots and the shifter are qualified by control state
   always_ff @(posedge i_clk) begin
      shifter_q <= shifter_d;
      if (push) mem_q[wr_ptr_q[c_aw-1:0]] <= i_data;
   end

endmodule
